// File: rtl/harris_window_sched.sv
// rtl/harris_window_sched.sv - 6x6 window fetch / Sobel tile sequencer for the Harris pipeline.
// Optional HARRIS_SCHED_REUSE_EN: reuse columns 4..5 on horizontal steps (24 reads instead of 36).
module harris_window_sched #(
  parameter int IMG_W  = 18,
  parameter int IMG_H  = 18,
  parameter int ADDR_W = 9,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [287:0]      win_flat,
  input  logic [127:0]      grad_gx_flat,
  input  logic [127:0]      grad_gy_flat,
  output logic [127:0]      tile_gx,
  output logic [127:0]      tile_gy,
  output logic [15:0]       tile_x,
  output logic [15:0]       tile_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SETTLE, S_OUT, S_DONE} state_t;

  localparam logic [15:0] X_LAST = 16'(IMG_W - 6);
  localparam logic [15:0] Y_LAST = 16'(IMG_H - 6);
`ifdef HARRIS_SCHED_REUSE_EN
  localparam logic [2:0] STEP_COL0 = 3'd2;
`else
  localparam logic [2:0] STEP_COL0 = 3'd0;
`endif

  state_t      state;
  logic [15:0] ox, oy;
  logic [2:0]  rd_r, rd_c, cap_r, cap_c, col0;
  logic        cap_pend;
  logic [15:0] scnt;

  logic        row_end, last_tile, rd_last;
  logic [15:0] nox, noy;
  logic [2:0]  nr, nc, next_col0;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [15:0] x, input logic [15:0] y,
                                                 input logic [2:0] r, input logic [2:0] c);
    return ADDR_W'((32'(y) + 32'(r)) * 32'(IMG_W) + 32'(x) + 32'(c));
  endfunction

  always_comb begin
    row_end   = (ox == X_LAST);
    last_tile = row_end && (oy == Y_LAST);
    nox       = row_end ? 16'd0 : ox + 16'd4;
    noy       = row_end ? oy + 16'd4 : oy;
    next_col0 = row_end ? 3'd0 : STEP_COL0;
    rd_last   = (rd_r == 3'd5) && (rd_c == 3'd5);
    nr        = (rd_c == 3'd5) ? rd_r + 3'd1 : rd_r;
    nc        = (rd_c == 3'd5) ? col0 : rd_c + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ox        <= '0;
      oy        <= '0;
      rd_r      <= '0;
      rd_c      <= '0;
      cap_r     <= '0;
      cap_c     <= '0;
      col0      <= '0;
      cap_pend  <= 1'b0;
      scnt      <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      win_flat  <= '0;
      tile_gx   <= '0;
      tile_gy   <= '0;
      tile_x    <= '0;
      tile_y    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ox        <= '0;
            oy        <= '0;
            col0      <= '0;
            rd_r      <= '0;
            rd_c      <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= pix_addr(16'd0, 16'd0, 3'd0, 3'd0);
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Issue and capture pipelines run in parallel; the capture side owns the exit.
          cap_pend <= mem_rd_en;
          if (mem_rd_en) begin
            cap_r <= rd_r;
            cap_c <= rd_c;
            if (rd_last) begin
              mem_rd_en <= 1'b0;
            end else begin
              rd_r     <= nr;
              rd_c     <= nc;
              mem_addr <= pix_addr(ox, oy, nr, nc);
            end
          end
          if (cap_pend) begin
            win_flat[(int'(cap_r) * 6 + int'(cap_c)) * 8 +: 8] <= mem_rd_data;
            if (cap_r == 3'd5 && cap_c == 3'd5) begin
              scnt  <= '0;
              state <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (scnt == 16'(SETTLE - 1)) begin
            tile_gx   <= grad_gx_flat;
            tile_gy   <= grad_gy_flat;
            tile_x    <= ox;
            tile_y    <= oy;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            scnt <= scnt + 16'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_tile) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              ox        <= nox;
              oy        <= noy;
              col0      <= next_col0;
              rd_r      <= 3'd0;
              rd_c      <= next_col0;
              mem_rd_en <= 1'b1;
              mem_addr  <= pix_addr(nox, noy, 3'd0, next_col0);
              state     <= S_FETCH;
`ifdef HARRIS_SCHED_REUSE_EN
              if (!row_end) begin
                for (int r = 0; r < 6; r++) begin
                  win_flat[(r * 6) * 8 +: 8]     <= win_flat[(r * 6 + 4) * 8 +: 8];
                  win_flat[(r * 6 + 1) * 8 +: 8] <= win_flat[(r * 6 + 5) * 8 +: 8];
                end
              end
`endif
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_harris_window_sched.sv
// tb/tb_harris_window_sched.sv - scoreboard bench for harris_window_sched with image-level reference model.
module tb_harris_window_sched;
  localparam int W  = 18;
  localparam int H  = 18;
  localparam int AW = 9;
`ifdef HARRIS_SCHED_REUSE_EN
  localparam int STEP_READS = 24;
`else
  localparam int STEP_READS = 36;
`endif

  logic          clk = 1'b0;
  logic          rst, start, mem_rd_en, out_valid, out_ready, busy, done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic [287:0]  win_flat;
  logic [127:0]  grad_gx_flat, grad_gy_flat, tile_gx, tile_gy;
  logic [15:0]   tile_x, tile_y;

  harris_window_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .win_flat(win_flat), .grad_gx_flat(grad_gx_flat),
    .grad_gy_flat(grad_gy_flat), .tile_gx(tile_gx), .tile_gy(tile_gy), .tile_x(tile_x),
    .tile_y(tile_y), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  x, y;
    logic [127:0] gx, gy;
    int           reads;
  } tile_t;

  tile_t      exp_q[$];
  logic [7:0] img[W*H];
  int compared = 0, mismatched = 0;
  int done_cnt = 0, accepted = 0, rd_cnt = 0, ready_mode = 0;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Environment gradient block: left-minus-right / top-minus-bottom Sobel on the window.
  function automatic int wp(input logic [287:0] w, input int r, input int c);
    return int'(w[(r * 6 + c) * 8 +: 8]);
  endfunction

  always_comb begin
    grad_gx_flat = '0;
    grad_gy_flat = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        grad_gx_flat[(i*4+j)*8 +: 8] = 8'((wp(win_flat,i,j) + 2*wp(win_flat,i+1,j) + wp(win_flat,i+2,j))
                                        - (wp(win_flat,i,j+2) + 2*wp(win_flat,i+1,j+2) + wp(win_flat,i+2,j+2)));
        grad_gy_flat[(i*4+j)*8 +: 8] = 8'((wp(win_flat,i,j) + 2*wp(win_flat,i,j+1) + wp(win_flat,i,j+2))
                                        - (wp(win_flat,i+2,j) + 2*wp(win_flat,i+2,j+1) + wp(win_flat,i+2,j+2)));
      end
    end
  end

  function automatic int ip(input int x, input int y);
    return int'(img[y * W + x]);
  endfunction

  // Reference: each tile is the Sobel response at image pixels (ox+1+j, oy+1+i), tiles in raster order.
  task automatic push_frame();
    tile_t t;
    int cx, cy, sx, sy, wt;
    for (int ty = 0; ty <= H - 6; ty += 4) begin
      for (int tx = 0; tx <= W - 6; tx += 4) begin
        t.x = 16'(tx);
        t.y = 16'(ty);
        t.reads = (tx == 0) ? 36 : STEP_READS;
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            cx = tx + j + 1;
            cy = ty + i + 1;
            sx = 0;
            sy = 0;
            for (int d = -1; d <= 1; d++) begin
              wt = (d == 0) ? 2 : 1;
              sx += wt * (ip(cx - 1, cy + d) - ip(cx + 1, cy + d));
              sy += wt * (ip(cx + d, cy - 1) - ip(cx + d, cy + 1));
            end
            t.gx[(i*4+j)*8 +: 8] = 8'(sx);
            t.gy[(i*4+j)*8 +: 8] = 8'(sy);
          end
        end
        exp_q.push_back(t);
      end
    end
  endtask

  // Pixel RAM: read issued in one cycle returns data in the next.
  initial begin
    logic          rd_s;
    logic [AW-1:0] a_s;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      rd_s = mem_rd_en;
      a_s  = mem_addr;
      @(posedge clk);
      #1;
      if (rd_s && int'(a_s) < W * H) mem_rd_data = img[int'(a_s)];
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom % 4) != 0;
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    tile_t        e;
    logic         stall_prev = 1'b0;
    logic [15:0]  sx, sy;
    logic [127:0] sgx, sgy;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_cnt     = 0;
        stall_prev = 1'b0;
      end else begin
        if (mem_rd_en) rd_cnt++;
        if (stall_prev) begin
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_tile", {tile_x, tile_y, tile_gx, tile_gy}, {sx, sy, sgx, sgy});
        end
        if (out_valid) chk("no_read_in_out", mem_rd_en, 1'b0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_tile", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("tile_x", tile_x, e.x);
            chk("tile_y", tile_y, e.y);
            chk("tile_gx", tile_gx, e.gx);
            chk("tile_gy", tile_gy, e.gy);
            chk("tile_reads", rd_cnt, e.reads);
          end
          rd_cnt = 0;
          accepted++;
        end
        stall_prev = out_valid && !out_ready;
        sx  = tile_x;
        sy  = tile_y;
        sgx = tile_gx;
        sgy = tile_gy;
        if (done) begin
          done_cnt++;
          chk("done_after_last", exp_q.size(), 0);
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_rd_en"}, mem_rd_en, 1'b0);
    chk({tag, "_addr"}, mem_addr, '0);
    chk({tag, "_win"}, win_flat, '0);
    chk({tag, "_gx"}, tile_gx, '0);
    chk({tag, "_gy"}, tile_gy, '0);
    chk({tag, "_tx"}, tile_x, '0);
    chk({tag, "_ty"}, tile_y, '0);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns #1 after the negedge inside the done cycle.
  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_accepted(input int target, input int budget);
    int n = 0;
    while (accepted < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (accepted < target) chk("accept_timeout", accepted, target);
  endtask

  initial begin
    int d0, a0, n;
    rst   = 1'b1;
    start = 1'b0;
    for (int k = 0; k < W * H; k++) img[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;

    // Frame 1: pixel = x, always ready, exact latency and address order.
    for (int k = 0; k < W * H; k++) img[k] = 8'(k % W);
    push_frame();
    ready_mode = 0;
    d0 = done_cnt;
    pulse_start();
    for (int c = 1; c <= 39; c++) begin
      @(negedge clk);
      chk($sformatf("rd_en_c%0d", c), mem_rd_en, c <= 36);
      if (c <= 36) chk($sformatf("addr_c%0d", c), mem_addr, AW'(((c - 1) / 6) * W + (c - 1) % 6));
      chk($sformatf("valid_c%0d", c), out_valid, c == 39);
    end
    chk("first_tile_gx", tile_gx, {16{8'hF8}});
    chk("first_tile_gy", tile_gy, 128'h0);
    wait_done(d0, 3000);
    chk("done_once_f1", done_cnt, d0 + 1);
    @(negedge clk);
    chk("idle_busy_f1", busy, 1'b0);

    // Frame 2: pixel = y, backpressure on the first tile then random ready.
    for (int k = 0; k < W * H; k++) img[k] = 8'(k / W);
    push_frame();
    ready_mode = 2;
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_valid", out_valid, 1'b1);
    repeat (10) @(negedge clk);
    chk("stall_end_valid", out_valid, 1'b1);
    chk("stall_end_gy", tile_gy, {16{8'hF8}});
    chk("stall_end_xy", {tile_x, tile_y}, 32'h0);
    ready_mode = 1;
    wait_done(d0, 4000);
    chk("done_once_f2", done_cnt, d0 + 1);
    @(negedge clk);

    // Frame 3: random image, reset during the fetch of tile 3.
    for (int k = 0; k < W * H; k++) img[k] = 8'($urandom);
    push_frame();
    a0 = accepted;
    pulse_start();
    wait_accepted(a0 + 2, 1000);
    n = 0;
    while (!mem_rd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("abort");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    d0 = done_cnt;
    repeat (100) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_idle", busy, 1'b0);

    // Frame 4: random image, start pulsed mid-frame and in the done cycle are ignored.
    for (int k = 0; k < W * H; k++) img[k] = 8'($urandom);
    push_frame();
    a0 = accepted;
    d0 = done_cnt;
    pulse_start();
    wait_accepted(a0 + 3, 1000);
    pulse_start();
    wait_done(d0, 4000);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_once_f4", done_cnt, d0 + 1);
    chk("tiles_f4", accepted - a0, 16);
    repeat (5) @(negedge clk);
    chk("done_start_ignored_busy", busy, 1'b0);
    chk("done_start_ignored_rd", mem_rd_en, 1'b0);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
